// File: rtl/pic_command_controller_if.sv
// CPU write bus into the PIC command controller: one-cycle write strobe, address bit A0, and data.
// Valid/ready: there is no ready. Each cycle with wr=1 is one complete write, and the controller always accepts it.
interface pic_command_controller_if;
  logic       wr;
  logic       a0;
  logic [7:0] din;

  modport master (output wr, a0, din);
  modport slave  (input  wr, a0, din);
endinterface

// File: rtl/pic_command_controller.sv
// 8259A-style command controller: sequences ICW1-ICW4 and decodes OCW1-OCW3 into static config and command pulses.
// Optional macro CASCADE_EN enables the ICW3 step and register; without it the part is always single mode.
module pic_command_controller #(
  parameter logic [7:0] IMR_RST = 8'hFF
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  pic_command_controller_if.slave   bus,
  output logic                      ltim_o,
  output logic                      sngl_o,
  output logic                      sfnm_o,
  output logic                      aeoi_o,
  output logic                      ar_o,
  output logic                      smm_o,
  output logic [4:0]                treg_o,
  output logic [7:0]                imr_o,
  output logic [7:0]                icw3_o,
  output logic                      read_irr_o,
  output logic                      read_isr_o,
  output logic                      init_done_o,
  output logic                      cmd_p_o,
  output logic [2:0]                cmd_code_o,
  output logic [2:0]                cmd_lvl_o,
  output logic                      poll_p_o,
  output logic [2:0]                state_o
);

  typedef enum logic [2:0] {
    S_UNINIT    = 3'd0,
    S_WAIT_ICW2 = 3'd1,
    S_WAIT_ICW3 = 3'd2,
    S_WAIT_ICW4 = 3'd3,
    S_READY     = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic       ltim_q, ltim_d;
  logic       sngl_q, sngl_d;
  logic       ic4_q, ic4_d;
  logic       sfnm_q, sfnm_d;
  logic       aeoi_q, aeoi_d;
  logic       ar_q, ar_d;
  logic       smm_q, smm_d;
  logic [4:0] treg_q, treg_d;
  logic [7:0] imr_q, imr_d;
  logic       rirr_q, rirr_d;
  logic       risr_q, risr_d;
  logic       cmd_p_q, cmd_p_d;
  logic [2:0] cmd_code_q, cmd_code_d;
  logic [2:0] cmd_lvl_q, cmd_lvl_d;
  logic       poll_p_q, poll_p_d;

  logic is_icw1;
  logic is_icw_data;
  logic is_ocw1;
  logic is_ocw2;
  logic is_ocw3;

  // ICW1 is recognised in every state, so a new ICW1 always restarts the init sequence.
  always_comb begin
    is_icw1     = bus.wr & ~bus.a0 & bus.din[4];
    is_icw_data = bus.wr & bus.a0 & (state_q != S_UNINIT) & (state_q != S_READY);
    is_ocw1     = bus.wr & bus.a0 & (state_q == S_READY);
    is_ocw2     = bus.wr & ~bus.a0 & (bus.din[4:3] == 2'b00) & (state_q == S_READY);
    is_ocw3     = bus.wr & ~bus.a0 & (bus.din[4:3] == 2'b01) & (state_q == S_READY);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_UNINIT;
    else          state_q <= state_d;
  end

  // Without CASCADE_EN, sngl_q is always 1 after ICW1, so WAIT_ICW3 is never entered.
  always_comb begin
    state_d = state_q;
    if (is_icw1) begin
      state_d = S_WAIT_ICW2;
    end else if (is_icw_data) begin
      case (state_q)
        S_WAIT_ICW2: state_d = !sngl_q ? S_WAIT_ICW3 : (ic4_q ? S_WAIT_ICW4 : S_READY);
        S_WAIT_ICW3: state_d = ic4_q ? S_WAIT_ICW4 : S_READY;
        S_WAIT_ICW4: state_d = S_READY;
        default:     state_d = state_q;
      endcase
    end
  end

  always_comb begin
    init_done_o = (state_q == S_READY);
    state_o     = state_q;
  end

  always_comb begin
    ltim_d     = ltim_q;
    sngl_d     = sngl_q;
    ic4_d      = ic4_q;
    sfnm_d     = sfnm_q;
    aeoi_d     = aeoi_q;
    ar_d       = ar_q;
    smm_d      = smm_q;
    treg_d     = treg_q;
    imr_d      = imr_q;
    rirr_d     = rirr_q;
    risr_d     = risr_q;
    cmd_p_d    = 1'b0;
    cmd_code_d = cmd_code_q;
    cmd_lvl_d  = cmd_lvl_q;
    poll_p_d   = 1'b0;

    if (is_icw1) begin
      ltim_d = bus.din[3];
`ifdef CASCADE_EN
      sngl_d = bus.din[1];
`else
      sngl_d = 1'b1;
`endif
      ic4_d  = bus.din[0];
      sfnm_d = 1'b0;
      aeoi_d = 1'b0;
      ar_d   = 1'b0;
      smm_d  = 1'b0;
      imr_d  = IMR_RST;
      rirr_d = 1'b1;
      risr_d = 1'b0;
    end else if (is_icw_data) begin
      if (state_q == S_WAIT_ICW2) treg_d = bus.din[7:3];
      if (state_q == S_WAIT_ICW4) begin
        sfnm_d = bus.din[4];
        aeoi_d = bus.din[1];
      end
    end else if (is_ocw1) begin
      imr_d = bus.din;
    end else if (is_ocw2) begin
      // 100/000 toggle rotate-in-AEOI, 010 is a no-op; every other code is a command pulse.
      case (bus.din[7:5])
        3'b100:  ar_d = 1'b1;
        3'b000:  ar_d = 1'b0;
        3'b010:  ;
        default: begin
          cmd_p_d    = 1'b1;
          cmd_code_d = bus.din[7:5];
          cmd_lvl_d  = bus.din[2:0];
        end
      endcase
    end else if (is_ocw3) begin
      if (bus.din[1]) begin
        rirr_d = ~bus.din[0];
        risr_d = bus.din[0];
      end
      if (bus.din[6]) smm_d = bus.din[5];
      if (bus.din[2]) poll_p_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ltim_q     <= 1'b0;
      sngl_q     <= 1'b0;
      ic4_q      <= 1'b0;
      sfnm_q     <= 1'b0;
      aeoi_q     <= 1'b0;
      ar_q       <= 1'b0;
      smm_q      <= 1'b0;
      treg_q     <= 5'd0;
      imr_q      <= IMR_RST;
      rirr_q     <= 1'b1;
      risr_q     <= 1'b0;
      cmd_p_q    <= 1'b0;
      cmd_code_q <= 3'd0;
      cmd_lvl_q  <= 3'd0;
      poll_p_q   <= 1'b0;
    end else begin
      ltim_q     <= ltim_d;
      sngl_q     <= sngl_d;
      ic4_q      <= ic4_d;
      sfnm_q     <= sfnm_d;
      aeoi_q     <= aeoi_d;
      ar_q       <= ar_d;
      smm_q      <= smm_d;
      treg_q     <= treg_d;
      imr_q      <= imr_d;
      rirr_q     <= rirr_d;
      risr_q     <= risr_d;
      cmd_p_q    <= cmd_p_d;
      cmd_code_q <= cmd_code_d;
      cmd_lvl_q  <= cmd_lvl_d;
      poll_p_q   <= poll_p_d;
    end
  end

`ifdef CASCADE_EN
  logic [7:0] icw3_q, icw3_d;

  always_comb begin
    icw3_d = icw3_q;
    if (is_icw_data && state_q == S_WAIT_ICW3) icw3_d = bus.din;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) icw3_q <= 8'd0;
    else          icw3_q <= icw3_d;
  end

  assign icw3_o = icw3_q;
`else
  assign icw3_o = 8'd0;
`endif

  assign ltim_o     = ltim_q;
  assign sngl_o     = sngl_q;
  assign sfnm_o     = sfnm_q;
  assign aeoi_o     = aeoi_q;
  assign ar_o       = ar_q;
  assign smm_o      = smm_q;
  assign treg_o     = treg_q;
  assign imr_o      = imr_q;
  assign read_irr_o = rirr_q;
  assign read_isr_o = risr_q;
  assign cmd_p_o    = cmd_p_q;
  assign cmd_code_o = cmd_code_q;
  assign cmd_lvl_o  = cmd_lvl_q;
  assign poll_p_o   = poll_p_q;

endmodule
